// File: rtl/sro_run_pkg.sv
// Shared types and widths for the SRO host-side run controller.
package sro_run_pkg;

  localparam int IW      = 9;
  localparam int DW      = 8;
  localparam int IMEM_AW = 16;
  localparam int DMEM_AW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_HOLD,
    S_DONE
  } run_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_RD,
    R_HOLD
  } rd_phase_t;

endpackage

// File: rtl/sro_dump_reader.sv
// Reads a window of data memory after halt and presents it as a byte stream.
module sro_dump_reader
  import sro_run_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [DMEM_AW-1:0] base,
  input  logic [7:0]         len,
  output logic               dmem_re,
  output logic [DMEM_AW-1:0] dmem_raddr,
  input  logic [DW-1:0]      dmem_rdata,
  output logic               dump_valid,
  output logic [DW-1:0]      dump_data,
  input  logic               dump_ready,
  output rd_phase_t          phase,
  output logic               finished
);

  rd_phase_t          phase_nxt;
  logic [DMEM_AW-1:0] base_q;
  logic [7:0]         len_q;
  logic [7:0]         off;
  logic               first_hold;
  logic [DW-1:0]      data_q;

  always_ff @(posedge clk) begin
    if (reset) phase <= R_IDLE;
    else       phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt  = phase;
    dmem_re    = 1'b0;
    dmem_raddr = '0;
    dump_valid = 1'b0;
    finished   = 1'b0;
    case (phase)
      R_IDLE: if (go) phase_nxt = R_RD;
      R_RD: begin
        dmem_re    = 1'b1;
        dmem_raddr = base_q + off;
        phase_nxt  = R_HOLD;
      end
      R_HOLD: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (off + 8'd1 == len_q) begin
            finished  = 1'b1;
            phase_nxt = R_IDLE;
          end else begin
            phase_nxt = R_RD;
          end
        end
      end
      default: phase_nxt = R_IDLE;
    endcase
  end

  // Read data arrives in the first HOLD cycle; forward it then and replay the
  // captured copy while the consumer stalls, so the byte never changes.
  assign dump_data = first_hold ? dmem_rdata : data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q     <= '0;
      len_q      <= '0;
      off        <= '0;
      first_hold <= 1'b0;
      data_q     <= '0;
    end else begin
      if (go && phase == R_IDLE) begin
        base_q <= base;
        len_q  <= len;
        off    <= '0;
      end
      first_hold <= (phase == R_RD);
      if (first_hold) data_q <= dmem_rdata;
      if (phase == R_HOLD && dump_ready) off <= off + 8'd1;
    end
  end

endmodule

// File: rtl/sro_run_ctrl.sv
// Host run controller: loads the program image, starts the core, waits for
// halt or timeout, then streams a data-memory window back out.
module sro_run_ctrl
  import sro_run_pkg::*;
#(
  parameter int PROG_DEPTH = 1024,
  parameter int START_CYC  = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [IW-1:0]      load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [IW-1:0]      imem_wdata,
  output logic               cpu_start,
  input  logic               cpu_halt,
  input  logic [DMEM_AW-1:0] dump_base,
  input  logic [7:0]         dump_len,
  output logic               dmem_sel,
  output logic               dmem_re,
  output logic [DMEM_AW-1:0] dmem_raddr,
  input  logic [DW-1:0]      dmem_rdata,
  output logic               dump_valid,
  output logic [DW-1:0]      dump_data,
  input  logic               dump_ready,
  output logic               done,
  output logic               timeout,
  output logic [31:0]        cycle_count,
  output run_state_t         dbg_state
);

  localparam int IDXW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
  localparam int SCW  = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  // Both streams transfer on a cycle where valid and ready are high together;
  // valid never waits on ready, and payload holds until that transfer cycle.

  run_state_t      state, state_nxt;
  rd_phase_t       rd_phase;
  logic [IDXW-1:0] idx, cur_idx;
  logic [SCW-1:0]  start_cnt;
  logic [31:0]     cycle_next;
  logic            load_fire, last_slot, run_timeout, dump_go, dump_finished;

  assign cur_idx     = (state == S_LOAD) ? idx : '0;
  assign last_slot   = (cur_idx == IDXW'(PROG_DEPTH - 1));
  assign load_fire   = load_valid && load_ready;
  assign cycle_next  = (cycle_count >= TIMEOUT_W) ? TIMEOUT_W : cycle_count + 32'd1;
  assign run_timeout = (cycle_next == TIMEOUT_W);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    cpu_start  = 1'b0;
    dmem_sel   = 1'b0;
    dump_go    = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_LOAD: begin
        load_ready = !reset;
        if (load_fire) state_nxt = (load_last || last_slot) ? S_START : S_LOAD;
      end
      S_START: begin
        cpu_start = 1'b1;
        if (start_cnt == SCW'(START_CYC - 1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (cpu_halt) begin
          if (dump_len == 8'd0) begin
            state_nxt = S_DONE;
          end else begin
            dump_go   = 1'b1;
            state_nxt = S_DUMP_RD;
          end
        end else if (run_timeout) begin
          state_nxt = S_DONE;
        end
      end
      S_DUMP_RD, S_DUMP_HOLD: begin
        dmem_sel = 1'b1;
        if (dump_finished) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we     <= 1'b0;
      imem_waddr  <= '0;
      imem_wdata  <= '0;
      idx         <= '0;
      start_cnt   <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      imem_we <= load_fire;
      if (load_fire) begin
        imem_waddr <= IMEM_AW'(cur_idx);
        imem_wdata <= load_data;
        idx        <= cur_idx + 1'b1;
      end
      if (load_fire && state != S_LOAD) begin
        done        <= 1'b0;
        timeout     <= 1'b0;
        cycle_count <= '0;
      end
      start_cnt <= (state == S_START) ? start_cnt + 1'b1 : '0;
      if (state == S_RUN) cycle_count <= cycle_next;
      // A halt in the final allowed cycle still counts as a clean finish.
      if (state == S_RUN && !cpu_halt && run_timeout) timeout <= 1'b1;
      if (state_nxt == S_DONE && state != S_DONE) done <= 1'b1;
    end
  end

  sro_dump_reader u_reader (
    .clk        (clk),
    .reset      (reset),
    .go         (dump_go),
    .base       (dump_base),
    .len        (dump_len),
    .dmem_re    (dmem_re),
    .dmem_raddr (dmem_raddr),
    .dmem_rdata (dmem_rdata),
    .dump_valid (dump_valid),
    .dump_data  (dump_data),
    .dump_ready (dump_ready),
    .phase      (rd_phase),
    .finished   (dump_finished)
  );

  assign dbg_state = (state == S_DUMP_RD && rd_phase == R_HOLD) ? S_DUMP_HOLD : state;

endmodule

// File: tb/tb_sro_run_ctrl.sv
// Directed bench for sro_run_ctrl with expected-value queues checked by monitors.
module tb_sro_run_ctrl;
  import sro_run_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid, load_last, load_ready;
  logic [8:0]  load_data;
  logic        imem_we;
  logic [15:0] imem_waddr;
  logic [8:0]  imem_wdata;
  logic        cpu_start, cpu_halt;
  logic [7:0]  dump_base, dump_len;
  logic        dmem_sel, dmem_re;
  logic [7:0]  dmem_raddr;
  logic [7:0]  dmem_rdata = '0;
  logic        dump_valid, dump_ready;
  logic [7:0]  dump_data;
  logic        done, timeout;
  logic [31:0] cycle_count;
  run_state_t  dbg_state;

  logic [7:0]  mem [256];
  logic [8:0]  prog [8];
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          dump_seen = 0;
  int          stall_cnt = 0;
  bit          stall_en = 0;

  logic [56:0] exp_wr_q[$];
  logic [7:0]  exp_dump_q[$];
  logic [32:0] exp_end_q[$];
  logic [7:0]  exp_start_q[$];

  sro_run_ctrl #(.PROG_DEPTH(4), .START_CYC(2), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_start(cpu_start), .cpu_halt(cpu_halt),
    .dump_base(dump_base), .dump_len(dump_len),
    .dmem_sel(dmem_sel), .dmem_re(dmem_re), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
    .done(done), .timeout(timeout), .cycle_count(cycle_count), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (dmem_re) dmem_rdata <= mem[dmem_raddr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name, input string what);
    n_vec++;
    n_miss++;
    $display("FAIL %s: %s", name, what);
  endtask

  // scoreboard monitors
  bit         held = 0;
  logic [7:0] held_data = '0;
  bit         done_q = 0;
  int         start_w = 0;

  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_wr_q.size() == 0) miss("imem_write", $sformatf("got addr %0h data %0h expected none", imem_waddr, imem_wdata));
      else check("imem_write", 64'({imem_waddr, imem_wdata, 32'(cyc)}), 64'(exp_wr_q.pop_front()));
    end
    if (dump_valid && held) check("dump_stable", 64'(dump_data), 64'(held_data));
    if (dump_valid && dump_ready) begin
      if (exp_dump_q.size() == 0) miss("dump_data", $sformatf("got %0h expected none", dump_data));
      else check("dump_data", 64'(dump_data), 64'(exp_dump_q.pop_front()));
      dump_seen++;
    end
    held      = dump_valid && !dump_ready;
    held_data = dump_data;
    if (cpu_start) start_w++;
    else if (start_w > 0) begin
      if (exp_start_q.size() == 0) miss("start_width", $sformatf("got %0d expected no pulse", start_w));
      else check("start_width", 64'(start_w), 64'(exp_start_q.pop_front()));
      start_w = 0;
    end
    if (done && !done_q) begin
      if (exp_end_q.size() == 0) miss("run_result", "got done expected none");
      else check("run_result", 64'({timeout, cycle_count}), 64'(exp_end_q.pop_front()));
    end
    done_q = done;
    if (dbg_state == S_RUN) check("dmem_sel_run", 64'(dmem_sel), 64'(0));
    if (dmem_re) check("dmem_sel_re", 64'(dmem_sel), 64'(1));
  end

  // dump_ready driver: stalls the second byte for two cycles when enabled
  initial begin
    dump_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_en && dump_valid && dump_seen == 1 && stall_cnt < 2) begin
        dump_ready = 1'b0;
        stall_cnt++;
      end else begin
        dump_ready = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic load_prog(input int n, input bit with_last);
    bit taken;
    for (int i = 0; i < n; i++) begin
      taken      = 0;
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = with_last && (i == n - 1);
      for (int t = 0; t < 20 && !taken; t++) begin
        @(negedge clk);
        if (load_ready) begin
          exp_wr_q.push_back({16'(i), prog[i], 32'(cyc + 1)});
          taken = 1;
        end
        @(posedge clk); #1;
      end
      if (!taken) miss("load_accept", $sformatf("word %0d got ready 0 expected accepted", i));
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic wait_run_start();
    bit seen;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (cpu_start) seen = 1;
      else if (seen) return;
      @(posedge clk); #1;
    end
    miss("run_entry", "got no start pulse end expected RUN entry");
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (done) return;
      @(posedge clk); #1;
    end
    miss("done_wait", "got done 0 expected 1");
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, 64'({imem_we, cpu_start, dmem_sel, dmem_re, dump_valid, done, timeout}), 64'(0));
    check({tag, "_buses"}, 64'({imem_waddr, imem_wdata, dmem_raddr, dump_data}), 64'(0));
    check({tag, "_cycle_count"}, 64'(cycle_count), 64'(0));
    check({tag, "_load_ready"}, 64'(load_ready), 64'(0));
    check({tag, "_state"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[8'hFE] = 8'h11;
    mem[8'hFF] = 8'h22;
    mem[8'h00] = 8'h33;
    mem[8'h10] = 8'h5A;
    reset = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    cpu_halt = 1'b0; dump_base = '0; dump_len = '0;
    repeat (2) @(posedge clk); #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_release_load_ready", 64'(load_ready), 64'(1));

    // A: three-word image, halt on 10th RUN cycle, no dump
    prog[0] = 9'h1A0; prog[1] = 9'h0FF; prog[2] = 9'h1E0;
    exp_start_q.push_back(8'd2);
    exp_end_q.push_back({1'b0, 32'd10});
    load_prog(3, 1);
    wait_run_start();
    repeat (9) @(posedge clk); #1;
    cpu_halt = 1'b1;
    wait_done();

    // B: stale halt ignored during START, dump wraps past 0xFF with a stall
    dump_base = 8'hFE; dump_len = 8'd3;
    dump_seen = 0; stall_cnt = 0; stall_en = 1;
    prog[0] = 9'h155;
    exp_start_q.push_back(8'd2);
    exp_dump_q.push_back(8'h11); exp_dump_q.push_back(8'h22); exp_dump_q.push_back(8'h33);
    exp_end_q.push_back({1'b0, 32'd1});
    load_prog(1, 1);
    wait_done();
    cpu_halt = 1'b0; stall_en = 0;

    // C: no halt, timeout aborts without a dump
    dump_base = 8'h00; dump_len = 8'd3;
    prog[0] = 9'h0AA;
    exp_start_q.push_back(8'd2);
    exp_end_q.push_back({1'b1, 32'd20});
    load_prog(1, 1);
    wait_done();

    // D: halt on the cycle the count reaches TIMEOUT, halt wins
    dump_base = 8'h10; dump_len = 8'd1;
    prog[0] = 9'h001;
    exp_start_q.push_back(8'd2);
    exp_dump_q.push_back(8'h5A);
    exp_end_q.push_back({1'b0, 32'd20});
    load_prog(1, 1);
    wait_run_start();
    repeat (19) @(posedge clk); #1;
    cpu_halt = 1'b1;
    wait_done();
    cpu_halt = 1'b0;

    // E: reset in the middle of RUN
    dump_len = 8'd0;
    prog[0] = 9'h0F0;
    exp_start_q.push_back(8'd2);
    load_prog(1, 1);
    wait_run_start();
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("mid_run_reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_load_ready", 64'(load_ready), 64'(1));

    // F: image longer than PROG_DEPTH is truncated
    prog[0] = 9'h101; prog[1] = 9'h102; prog[2] = 9'h103; prog[3] = 9'h104;
    exp_start_q.push_back(8'd2);
    exp_end_q.push_back({1'b0, 32'd3});
    load_prog(4, 0);
    load_valid = 1'b1; load_data = 9'h1FF;
    @(negedge clk);
    check("trunc_load_ready", 64'(load_ready), 64'(0));
    check("trunc_start", 64'(cpu_start), 64'(1));
    @(posedge clk); #1;
    load_valid = 1'b0;
    wait_run_start();
    repeat (2) @(posedge clk); #1;
    cpu_halt = 1'b1;
    wait_done();
    cpu_halt = 1'b0;
    repeat (3) @(posedge clk); #1;

    check("left_writes", 64'(exp_wr_q.size()), 64'(0));
    check("left_dump", 64'(exp_dump_q.size()), 64'(0));
    check("left_results", 64'(exp_end_q.size()), 64'(0));
    check("left_starts", 64'(exp_start_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
